// File: rtl/update_bound_pkg.sv
// Shared types, position codes and C table for the update_bound backward-search stage.
// Position codes follow the common config encoding used by the neighbouring stages.
package update_bound_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 12;
  localparam int POS_W  = 5;

  localparam logic [DATA_W-1:0] C_A = 8'd0;
  localparam logic [DATA_W-1:0] C_C = 8'd5;
  localparam logic [DATA_W-1:0] C_G = 8'd9;
  localparam logic [DATA_W-1:0] C_T = 8'd12;

  localparam logic [POS_W-1:0] POS_NONE    = 5'd0;
  localparam logic [POS_W-1:0] POS_A_MATCH = 5'd1;
  localparam logic [POS_W-1:0] POS_C_MATCH = 5'd2;
  localparam logic [POS_W-1:0] POS_G_MATCH = 5'd3;
  localparam logic [POS_W-1:0] POS_T_MATCH = 5'd4;
  localparam logic [POS_W-1:0] POS_A_INS   = 5'd5;
  localparam logic [POS_W-1:0] POS_C_INS   = 5'd6;
  localparam logic [POS_W-1:0] POS_G_INS   = 5'd7;
  localparam logic [POS_W-1:0] POS_T_INS   = 5'd8;
  localparam logic [POS_W-1:0] POS_A_DEL   = 5'd9;
  localparam logic [POS_W-1:0] POS_C_DEL   = 5'd10;
  localparam logic [POS_W-1:0] POS_G_DEL   = 5'd11;
  localparam logic [POS_W-1:0] POS_T_DEL   = 5'd12;
  localparam logic [POS_W-1:0] POS_A_SNP   = 5'd13;
  localparam logic [POS_W-1:0] POS_C_SNP   = 5'd14;
  localparam logic [POS_W-1:0] POS_G_SNP   = 5'd15;
  localparam logic [POS_W-1:0] POS_T_SNP   = 5'd16;
  localparam logic [POS_W-1:0] POS_STOP_OK = 5'd17;
  localparam logic [POS_W-1:0] POS_STOP_NG = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

  // Insertion and deletion codes are contiguous; everything else passes through.
  function automatic logic is_compute(input logic [POS_W-1:0] pos);
    logic r;
    if ((pos >= POS_A_INS) && (pos <= POS_T_DEL)) r = 1'b1;
    else r = 1'b0;
    return r;
  endfunction

  function automatic base_t pos_base(input logic [POS_W-1:0] pos);
    base_t b;
    case (pos)
      POS_A_INS, POS_A_DEL: b = BASE_A;
      POS_C_INS, POS_C_DEL: b = BASE_C;
      POS_G_INS, POS_G_DEL: b = BASE_G;
      POS_T_INS, POS_T_DEL: b = BASE_T;
      default:              b = BASE_A;
    endcase
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] c_of(input base_t b);
    logic [DATA_W-1:0] c;
    case (b)
      BASE_A:  c = C_A;
      BASE_C:  c = C_C;
      BASE_G:  c = C_G;
      BASE_T:  c = C_T;
      default: c = C_A;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/update_bound_occ_lane_sel.sv
// Picks the Occ byte lane for one base out of a packed {T,G,C,A} rom_Occ word.
module occ_lane_sel
  import update_bound_pkg::*;
(
  input  logic [31:0]       word,
  input  base_t             base,
  output logic [DATA_W-1:0] lane
);

  // lane mux
  always_comb begin
    lane = 8'd0;
    case (base)
      BASE_A:  lane = word[7:0];
      BASE_C:  lane = word[15:8];
      BASE_G:  lane = word[23:16];
      BASE_T:  lane = word[31:24];
      default: lane = 8'd0;
    endcase
  end

endmodule

// File: rtl/update_bound.sv
// Backward-search interval update: fetches Occ(a,l) and produces k'=C(a)+Occ(a,k-1)+1,
// l'=C(a)+Occ(a,l), flagging a non-empty, non-overflowed interval as a hit.
module update_bound
  import update_bound_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] z_in,
  input  logic [DATA_W-1:0] k_in,
  input  logic [DATA_W-1:0] l_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [POS_W-1:0]  position_in,
  input  logic [DATA_W-1:0] occ_k_in,
  output logic              ce_rom_Occ,
  output logic [7:0]        addr_rom_Occ,
  input  logic [31:0]       data_rom_Occ,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] i_out,
  output logic [DATA_W-1:0] z_out,
  output logic [DATA_W-1:0] k_out,
  output logic [DATA_W-1:0] l_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [POS_W-1:0]  position_out,
  output logic              hit
);

  state_t            state_r, state_s;
  base_t             base_r;
  logic              k_zero_r;
  logic [DATA_W-1:0] occ_k_r;
  logic [DATA_W-1:0] occ_l_s;
  logic [DATA_W-1:0] c_val_s;
  logic [DATA_W:0]   k_sum_s, l_sum_s;
  logic              accept_s, compute_s;

  assign accept_s  = in_valid & in_ready;
  assign compute_s = is_compute(position_in);

  occ_lane_sel u_lane (
    .word (data_rom_Occ),
    .base (base_r),
    .lane (occ_l_s)
  );

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (compute_s) state_s = ST_RD;
          else state_s = ST_OUT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD:   state_s = ST_WAIT;
      ST_WAIT: state_s = ST_OUT;
      ST_OUT: begin
        if (out_ready) state_s = ST_IDLE;
        else state_s = ST_OUT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Occ(a,-1) is 0, so k==0 drops the upstream lane; sums keep one carry bit
  always_comb begin
    c_val_s = c_of(base_r);
    if (k_zero_r) k_sum_s = {1'b0, c_val_s} + {{DATA_W{1'b0}}, 1'b1};
    else k_sum_s = {1'b0, c_val_s} + {1'b0, occ_k_r} + {{DATA_W{1'b0}}, 1'b1};
    l_sum_s = {1'b0, c_val_s} + {1'b0, occ_l_s};
  end

  // state and handshake/control outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready   <= 1'b1;
      ce_rom_Occ <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready   <= (state_s == ST_IDLE);
      ce_rom_Occ <= (state_s == ST_RD);
      out_valid  <= (state_s == ST_OUT);
    end
  end

  // capture on accept, overwrite the interval once the ROM lane is available
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_out        <= 8'd0;
      z_out        <= 8'd0;
      k_out        <= 8'd0;
      l_out        <= 8'd0;
      addr_out     <= 12'd0;
      position_out <= 5'd0;
      hit          <= 1'b0;
      addr_rom_Occ <= 8'd0;
      occ_k_r      <= 8'd0;
      base_r       <= BASE_A;
      k_zero_r     <= 1'b0;
    end else if (accept_s) begin
      i_out        <= i_in;
      z_out        <= z_in;
      k_out        <= k_in;
      l_out        <= l_in;
      addr_out     <= addr_in;
      position_out <= position_in;
      hit          <= 1'b0;
      occ_k_r      <= occ_k_in;
      base_r       <= pos_base(position_in);
      k_zero_r     <= (k_in == 8'd0);
      if (compute_s) addr_rom_Occ <= l_in;
      else addr_rom_Occ <= addr_rom_Occ;
    end else if (state_r == ST_WAIT) begin
      k_out <= k_sum_s[DATA_W-1:0];
      l_out <= l_sum_s[DATA_W-1:0];
      hit   <= ~k_sum_s[DATA_W] & ~l_sum_s[DATA_W]
               & (k_sum_s[DATA_W-1:0] <= l_sum_s[DATA_W-1:0]);
    end
  end

endmodule

// File: tb/tb_update_bound.sv
// Self-checking bench for update_bound: directed table, handshake/reset corners and
// randomized transactions scored against an arithmetic reference model.
module tb_update_bound;
  import update_bound_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        i_in = 8'd0, z_in = 8'd0, k_in = 8'd0, l_in = 8'd0, occ_k_in = 8'd0;
  logic [11:0]       addr_in = 12'd0;
  logic [4:0]        position_in = 5'd0;
  logic              ce_rom_Occ;
  logic [7:0]        addr_rom_Occ;
  logic [31:0]       data_rom_Occ = 32'd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        i_out, z_out, k_out, l_out;
  logic [11:0]       addr_out;
  logic [4:0]        position_out;
  logic              hit;

  logic [31:0] rom [256];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  pos;
    logic [7:0]  k;
    logic [7:0]  l;
    logic [7:0]  occ;
    logic [31:0] word;
    logic [7:0]  ek;
    logic [7:0]  el;
    logic        eh;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[$];

  update_bound dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .i_in(i_in), .z_in(z_in), .k_in(k_in), .l_in(l_in), .addr_in(addr_in),
    .position_in(position_in), .occ_k_in(occ_k_in),
    .ce_rom_Occ(ce_rom_Occ), .addr_rom_Occ(addr_rom_Occ), .data_rom_Occ(data_rom_Occ),
    .out_valid(out_valid), .out_ready(out_ready),
    .i_out(i_out), .z_out(z_out), .k_out(k_out), .l_out(l_out),
    .addr_out(addr_out), .position_out(position_out), .hit(hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce_rom_Occ) data_rom_Occ <= rom[addr_rom_Occ];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: interval update straight from the arithmetic definition
  function automatic vec_t model(input logic [4:0] pos, input logic [7:0] k, input logic [7:0] l,
                                 input logic [7:0] occ, input logic [31:0] word);
    vec_t v;
    int ctab[4] = '{0, 5, 9, 12};
    int b, kp, lp, lane;
    v.pos = pos; v.k = k; v.l = l; v.occ = occ; v.word = word; v.hold = 0;
    b = -1;
    case (pos)
      POS_A_INS, POS_A_DEL: b = 0;
      POS_C_INS, POS_C_DEL: b = 1;
      POS_G_INS, POS_G_DEL: b = 2;
      POS_T_INS, POS_T_DEL: b = 3;
      default:              b = -1;
    endcase
    if (b < 0) begin
      v.ek = k; v.el = l; v.eh = 1'b0; v.lat = 1;
    end else begin
      lane = int'((word >> (8 * b)) & 32'hFF);
      kp = ctab[b] + ((k == 8'd0) ? 0 : int'(occ)) + 1;
      lp = ctab[b] + lane;
      v.ek = kp[7:0]; v.el = lp[7:0];
      v.eh = (kp < 256) && (lp < 256) && (kp <= lp);
      v.lat = 3;
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    logic [7:0]  iv = 8'($urandom);
    logic [7:0]  zv = 8'($urandom);
    logic [11:0] av = 12'($urandom);
    int cyc = 0;
    int ce_cnt = 0;
    bit comp = (v.lat == 3);
    rom[v.l] = v.word;
    @(negedge clk);
    in_valid = 1'b1; position_in = v.pos; k_in = v.k; l_in = v.l; occ_k_in = v.occ;
    i_in = iv; z_in = zv; addr_in = av;
    out_ready = (v.hold == 0);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k_in = 8'($urandom); l_in = 8'($urandom); occ_k_in = 8'($urandom); position_in = 5'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 8) begin
      if (ce_rom_Occ) begin
        ce_cnt++;
        check("ce_cycle", 32'(cyc), 32'd1);
        check("ce_addr", 32'(addr_rom_Occ), 32'(v.l));
      end
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) begin
      check("out_timeout", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      return;
    end
    check("latency", 32'(cyc), 32'(v.lat));
    check("ce_count", 32'(ce_cnt), comp ? 32'd1 : 32'd0);
    if (comp) check("addr_rom_hold", 32'(addr_rom_Occ), 32'(v.l));
    for (int h = 0; h <= v.hold; h++) begin
      check("out_valid", 32'(out_valid), 32'd1);
      check("in_ready_out", 32'(in_ready), 32'd0);
      check("ce_out", 32'(ce_rom_Occ), 32'd0);
      check("k_out", 32'(k_out), 32'(v.ek));
      check("l_out", 32'(l_out), 32'(v.el));
      check("hit", 32'(hit), 32'(v.eh));
      check("i_out", 32'(i_out), 32'(iv));
      check("z_out", 32'(z_out), 32'(zv));
      check("addr_out", 32'(addr_out), 32'(av));
      check("position_out", 32'(position_out), 32'(v.pos));
      if (h == v.hold) out_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  function automatic vec_t mk(input logic [4:0] pos, input logic [7:0] k, input logic [7:0] l,
                              input logic [7:0] occ, input logic [31:0] word, input logic [7:0] ek,
                              input logic [7:0] el, input logic eh, input int lat, input int hold);
    vec_t v;
    v.pos = pos; v.k = k; v.l = l; v.occ = occ; v.word = word;
    v.ek = ek; v.el = el; v.eh = eh; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  initial begin
    vec_t v;
    for (int a = 0; a < 256; a++) rom[a] = 32'd0;

    vecs.push_back(mk(POS_A_DEL,   8'd3,  8'd6,   8'd1,   32'h04030203, 8'd2,   8'd3,   1'b1, 3, 0));
    vecs.push_back(mk(POS_T_INS,   8'd0,  8'd2,   8'hFF,  32'h00000000, 8'd13,  8'd12,  1'b0, 3, 0));
    vecs.push_back(mk(POS_G_DEL,   8'd4,  8'd200, 8'd1,   32'h00FA0000, 8'd11,  8'h03,  1'b0, 3, 0));
    vecs.push_back(mk(POS_A_MATCH, 8'd5,  8'd9,   8'd77,  32'h12345678, 8'd5,   8'd9,   1'b0, 1, 0));
    vecs.push_back(mk(POS_C_INS,   8'd10, 8'd20,  8'd3,   32'h11220733, 8'd9,   8'd12,  1'b1, 3, 0));
    vecs.push_back(mk(POS_T_DEL,   8'd7,  8'd30,  8'hF4,  32'hF0000000, 8'h01,  8'd252, 1'b0, 3, 0));
    vecs.push_back(mk(POS_G_INS,   8'd0,  8'd40,  8'd50,  32'h00010000, 8'd10,  8'd10,  1'b1, 3, 0));
    vecs.push_back(mk(POS_NONE,    8'd1,  8'd2,   8'd3,   32'hFFFFFFFF, 8'd1,   8'd2,   1'b0, 1, 0));
    vecs.push_back(mk(5'd31,       8'd88, 8'd99,  8'd4,   32'hFFFFFFFF, 8'd88,  8'd99,  1'b0, 1, 0));
    vecs.push_back(mk(POS_A_DEL,   8'd3,  8'd6,   8'd1,   32'h04030203, 8'd2,   8'd3,   1'b1, 3, 5));
    vecs.push_back(mk(POS_C_SNP,   8'd6,  8'd7,   8'd8,   32'h0,        8'd6,   8'd7,   1'b0, 1, 5));

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ce", 32'(ce_rom_Occ), 32'd0);
    check("rst_k_out", 32'(k_out), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) run_txn(vecs[n]);

    // Reset while the ROM read is in flight
    rom[8'd6] = 32'h04030203;
    @(negedge clk);
    in_valid = 1'b1; position_in = POS_A_DEL; k_in = 8'd3; l_in = 8'd6; occ_k_in = 8'd1;
    i_in = 8'h5A; z_in = 8'hA5; addr_in = 12'hABC; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rd_ce", 32'(ce_rom_Occ), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ce", 32'(ce_rom_Occ), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_addr_rom", 32'(addr_rom_Occ), 32'd0);
    check("arst_outs", {i_out, z_out, k_out, l_out}, 32'd0);
    check("arst_addr_pos", {15'd0, addr_out, position_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(vecs[0]);

    for (int r = 0; r < 40; r++) begin
      logic [7:0] rk, rl;
      rk = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      rl = 8'($urandom);
      v = model(5'($urandom_range(0, 31)), rk, rl, 8'($urandom), $urandom);
      v.hold = $urandom_range(0, 2);
      run_txn(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
